// File: rtl/ika87ad_mcsequencer_if.sv
// Signal bundle between the microcode sequencer and its decoder, ROM,
// bus controller and flag logic. Names keep the sequencer's point of view.
interface ika87ad_mcsequencer_if #(
  parameter int MC_W = 18
);
  logic            i_CEN;
  logic            i_DEC_VALID;
  logic [7:0]      i_DEC_ADDR;
  logic [MC_W-1:0] i_MCROM_DATA;
  logic            i_BUS_DONE;
  logic            i_SKIP_COND;
  logic            i_ABORT;
  logic            o_MCROM_READ_TICK;
  logic [7:0]      o_MCROM_ADDR;
  logic [MC_W-1:0] o_MC_WORD;
  logic            o_MC_VALID;
  logic            o_BUS_REQ;
  logic [1:0]      o_BUS_CODE;
  logic            o_IRD;
  logic            o_SKIP_PEND;
  logic            o_SEQ_ERR;

  // The sequencer itself
  modport master (
    input  i_CEN, i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA,
           i_BUS_DONE, i_SKIP_COND, i_ABORT,
    output o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID,
           o_BUS_REQ, o_BUS_CODE, o_IRD, o_SKIP_PEND, o_SEQ_ERR
  );

  // Everything around the sequencer
  modport slave (
    output i_CEN, i_DEC_VALID, i_DEC_ADDR, i_MCROM_DATA,
           i_BUS_DONE, i_SKIP_COND, i_ABORT,
    input  o_MCROM_READ_TICK, o_MCROM_ADDR, o_MC_WORD, o_MC_VALID,
           o_BUS_REQ, o_BUS_CODE, o_IRD, o_SKIP_PEND, o_SEQ_ERR
  );
endinterface

// File: rtl/ika87ad_mcsequencer.sv
// Microcode sequencer: waits in decode-wait (IRD) for an entry point, then
// loops fetch -> latch -> bus wait over consecutive microwords until a word
// with END set (or an abort) finishes the instruction.
module ika87ad_mcsequencer #(
  parameter logic [7:0] IRD_ADDR = 8'hFF,
  parameter int         MC_W     = 18
) (
  input logic                   i_CLK,
  input logic                   i_RST_n,
  ika87ad_mcsequencer_if.master bus
);

  // Microword control bits; [17:16] MCTYPE is only passed through
  localparam int END_BIT     = 15;
  localparam int SKIPCHK_BIT = 14;

  typedef enum logic [1:0] {
    ST_IRD     = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_BUSWAIT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [MC_W-1:0] mc_word_q, mc_word_d;
  logic            mc_valid_q, mc_valid_d;
  logic            bus_req_q, bus_req_d;
  logic [1:0]      bus_code_q, bus_code_d;
  logic            skip_pend_q, skip_pend_d;
  logic            seq_err_q, seq_err_d;
  logic            abort_pend_q, abort_pend_d;

  logic            abort_any;
  logic            word_end;
  logic            ird;
  logic            read_tick;
  logic [7:0]      rom_addr;

  // An abort raised at any point of the bus wait takes effect at bus done
  assign abort_any = abort_pend_q | bus.i_ABORT;
  assign word_end  = mc_word_q[END_BIT];

  // State register; nothing advances while the processor clock enable is low
  always_ff @(posedge i_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (!i_RST_n)       state_q <= ST_IRD;
    else if (bus.i_CEN) state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IRD:     if (bus.i_DEC_VALID) state_d = ST_FETCH;
      ST_FETCH:   state_d = bus.i_ABORT ? ST_IRD : ST_LATCH;
      ST_LATCH:   state_d = bus.i_ABORT ? ST_IRD : ST_BUSWAIT;
      ST_BUSWAIT: if (bus.i_BUS_DONE) state_d = (abort_any || word_end) ? ST_IRD : ST_FETCH;
      default:    state_d = ST_IRD;
    endcase
  end

  // State-decoded outputs; the read tick is gated so it never repeats while stalled
  always_comb begin
    ird       = (state_q == ST_IRD);
    read_tick = (state_q == ST_FETCH) && bus.i_CEN;
    rom_addr  = ird ? IRD_ADDR : addr_q;
  end

  // Datapath next values: address, latched word, bus request, skip and error flags
  always_comb begin
    addr_d       = addr_q;
    mc_word_d    = mc_word_q;
    mc_valid_d   = 1'b0;
    bus_req_d    = bus_req_q;
    bus_code_d   = bus_code_q;
    skip_pend_d  = skip_pend_q;
    seq_err_d    = seq_err_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IRD: begin
        // Decode wins over a simultaneous abort: abort is not looked at here
        if (bus.i_DEC_VALID) addr_d = bus.i_DEC_ADDR;
      end
      ST_LATCH: begin
        if (!bus.i_ABORT) begin
          mc_word_d  = bus.i_MCROM_DATA;
          mc_valid_d = 1'b1;
          bus_req_d  = 1'b1;
          bus_code_d = bus.i_MCROM_DATA[1:0];
        end
      end
      ST_BUSWAIT: begin
        if (bus.i_BUS_DONE) begin
          bus_req_d    = 1'b0;
          abort_pend_d = 1'b0;
          // END always updates the skip flag; only SKIPCHK lets the condition in
          if (word_end) skip_pend_d = mc_word_q[SKIPCHK_BIT] & bus.i_SKIP_COND;
          if (!abort_any && !word_end) begin
            addr_d = addr_q + 8'd1;
            if (addr_q == 8'hFF) seq_err_d = 1'b1;
          end
        end else if (bus.i_ABORT) begin
          abort_pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; synchronous reset overrides the clock enable
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      addr_q       <= IRD_ADDR;
      mc_word_q    <= '0;
      mc_valid_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_code_q   <= 2'b00;
      skip_pend_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else if (bus.i_CEN) begin
      addr_q       <= addr_d;
      mc_word_q    <= mc_word_d;
      mc_valid_q   <= mc_valid_d;
      bus_req_q    <= bus_req_d;
      bus_code_q   <= bus_code_d;
      skip_pend_q  <= skip_pend_d;
      seq_err_q    <= seq_err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // The valid strobe only counts on an enabled cycle, so a stall cannot duplicate it
  assign bus.o_MCROM_READ_TICK = read_tick;
  assign bus.o_MCROM_ADDR      = rom_addr;
  assign bus.o_MC_WORD         = mc_word_q;
  assign bus.o_MC_VALID        = mc_valid_q & bus.i_CEN;
  assign bus.o_BUS_REQ         = bus_req_q;
  assign bus.o_BUS_CODE        = bus_code_q;
  assign bus.o_IRD             = ird;
  assign bus.o_SKIP_PEND       = skip_pend_q;
  assign bus.o_SEQ_ERR         = seq_err_q;

endmodule

// File: tb/tb_ika87ad_mcsequencer.sv
// Bench for the microcode sequencer: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_ika87ad_mcsequencer;
  localparam int MC_W = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ika87ad_mcsequencer_if #(.MC_W(MC_W)) sif ();

  ika87ad_mcsequencer #(.IRD_ADDR(8'hFF), .MC_W(MC_W)) dut (
    .i_CLK  (clk),
    .i_RST_n(rst_n),
    .bus    (sif)
  );

  // Synchronous ROM: output register loads on a read tick
  logic [MC_W-1:0] rom [256];
  logic [MC_W-1:0] rom_q = '0;
  always @(posedge clk) if (sif.o_MCROM_READ_TICK) rom_q <= rom[sif.o_MCROM_ADDR];
  assign sif.i_MCROM_DATA = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: idle flag, micro-pc, phase of the current word
  // (0 read, 1 capture, 2 bus), plus the architectural flags.
  bit              m_live = 1'b0;
  bit              m_idle = 1'b1;
  int              m_phase = 0;
  int              m_pc = 255;
  logic [MC_W-1:0] m_word = '0;
  bit              m_valid = 1'b0;
  bit              m_req = 1'b0;
  logic [1:0]      m_code = 2'b00;
  bit              m_skip = 1'b0;
  bit              m_err = 1'b0;
  bit              m_abort_pend = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live <= 1'b1; m_idle <= 1'b1; m_phase <= 0; m_pc <= 255; m_word <= '0;
      m_valid <= 1'b0; m_req <= 1'b0; m_code <= 2'b00; m_skip <= 1'b0;
      m_err <= 1'b0; m_abort_pend <= 1'b0;
    end else if (sif.i_CEN) begin
      m_valid <= 1'b0;
      if (m_idle) begin
        if (sif.i_DEC_VALID) begin
          m_idle <= 1'b0; m_pc <= int'(sif.i_DEC_ADDR); m_phase <= 0;
        end
      end else if (m_phase == 0) begin
        if (sif.i_ABORT) m_idle <= 1'b1; else m_phase <= 1;
      end else if (m_phase == 1) begin
        if (sif.i_ABORT) m_idle <= 1'b1;
        else begin
          m_word <= rom[m_pc]; m_valid <= 1'b1; m_req <= 1'b1;
          m_code <= rom[m_pc][1:0]; m_phase <= 2;
        end
      end else if (sif.i_BUS_DONE) begin
        m_req <= 1'b0; m_abort_pend <= 1'b0;
        if (m_word[15]) m_skip <= m_word[14] & sif.i_SKIP_COND;
        if (m_abort_pend || sif.i_ABORT || m_word[15]) m_idle <= 1'b1;
        else begin
          if (m_pc == 255) m_err <= 1'b1;
          m_pc <= (m_pc + 1) % 256; m_phase <= 0;
        end
      end else if (sif.i_ABORT) begin
        m_abort_pend <= 1'b1;
      end
    end
  end

  // Event logs for the directed literal checks
  logic [7:0] tick_log [$];
  logic [1:0] code_log [$];
  int         n_valid = 0;

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      check("ird",   32'(sif.o_IRD),             32'(m_idle));
      check("tick",  32'(sif.o_MCROM_READ_TICK), 32'(!m_idle && m_phase == 0 && sif.i_CEN));
      check("addr",  32'(sif.o_MCROM_ADDR),      m_idle ? 32'hFF : 32'(m_pc));
      check("word",  32'(sif.o_MC_WORD),         32'(m_word));
      check("valid", 32'(sif.o_MC_VALID),        32'(m_valid && sif.i_CEN));
      check("req",   32'(sif.o_BUS_REQ),         32'(m_req));
      check("code",  32'(sif.o_BUS_CODE),        32'(m_code));
      check("skip",  32'(sif.o_SKIP_PEND),       32'(m_skip));
      check("err",   32'(sif.o_SEQ_ERR),         32'(m_err));
      if (sif.o_MCROM_READ_TICK) tick_log.push_back(sif.o_MCROM_ADDR);
      if (sif.o_MC_VALID) begin
        code_log.push_back(sif.o_BUS_CODE);
        n_valid++;
      end
    end
  end

  // Stimulus controls
  bit rnd = 1'b0;
  int cen_mode = 0;     // 0 always on, 1 alternate, 2 random, 3 leave as is
  int done_delay = 2;
  int req_age = 0;
  bit hold_dec = 1'b0;
  int abort_phase = -1;

  task automatic step();
    @(posedge clk);
    #1;
    if (sif.i_ABORT && sif.i_CEN) abort_phase = -1;
    if (hold_dec && !sif.o_IRD) hold_dec = 1'b0;
    if (sif.o_BUS_REQ) req_age++; else req_age = 0;
    if (rnd) begin
      rst_n           = ($urandom_range(0, 299) != 0);
      sif.i_CEN       = ($urandom_range(0, 3) != 0);
      sif.i_DEC_VALID = ($urandom_range(0, 3) == 0);
      sif.i_DEC_ADDR  = 8'($urandom_range(0, 255));
      sif.i_BUS_DONE  = ($urandom_range(0, 2) == 0);
      sif.i_ABORT     = ($urandom_range(0, 19) == 0);
      sif.i_SKIP_COND = 1'($urandom_range(0, 1));
    end else begin
      case (cen_mode)
        0:       sif.i_CEN = 1'b1;
        1:       sif.i_CEN = ~sif.i_CEN;
        2:       sif.i_CEN = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      sif.i_DEC_VALID = hold_dec;
      sif.i_BUS_DONE  = sif.o_BUS_REQ && (req_age >= done_delay);
      sif.i_ABORT     = (abort_phase >= 0) && !m_idle && (m_phase == abort_phase);
    end
  endtask

  task automatic run_instr(input logic [7:0] entry, input string name);
    int n;
    tick_log.delete();
    code_log.delete();
    n_valid = 0;
    sif.i_DEC_ADDR = entry;
    hold_dec = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!(sif.o_IRD && !hold_dec) && n < 200);
    check({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    sif.i_CEN = 1'b1; sif.i_DEC_VALID = 1'b0; sif.i_DEC_ADDR = 8'h00;
    sif.i_BUS_DONE = 1'b0; sif.i_SKIP_COND = 1'b0; sif.i_ABORT = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic two-word instruction
    rom[8'h10] = 18'h20001;   // MCTYPE 2, END 0, code 01
    rom[8'h11] = 18'h18000;   // MCTYPE 1, END 1, code 00
    for (int pass = 0; pass < 2; pass++) begin
      cen_mode = pass;
      run_instr(8'h10, pass == 0 ? "basic" : "cen_toggle");
      check("ticks_n", 32'(tick_log.size()), 32'd2);
      if (tick_log.size() == 2) begin
        check("tick0", 32'(tick_log[0]), 32'h10);
        check("tick1", 32'(tick_log[1]), 32'h11);
      end
      check("valid_n", 32'(n_valid), 32'd2);
      if (code_log.size() == 2) begin
        check("code0", 32'(code_log[0]), 32'd1);
        check("code1", 32'(code_log[1]), 32'd0);
      end
      check("ird_back", 32'(sif.o_IRD), 32'd1);
      check("last_word", 32'(sif.o_MC_WORD), 32'h18000);
    end
    cen_mode = 0;

    // Skip flag load and clear
    rom[8'h20] = 18'h0C002;   // END 1, SKIPCHK 1
    rom[8'h30] = 18'h08003;   // END 1, SKIPCHK 0
    sif.i_SKIP_COND = 1'b1;
    run_instr(8'h20, "skip_set");
    check("skip_set", 32'(sif.o_SKIP_PEND), 32'd1);
    run_instr(8'h30, "skip_clr");
    check("skip_clr", 32'(sif.o_SKIP_PEND), 32'd0);
    sif.i_SKIP_COND = 1'b0;

    // Abort in the capture phase: no valid strobe
    rom[8'h40] = 18'h38001;
    abort_phase = 1;
    run_instr(8'h40, "abort_latch");
    check("abl_ticks", 32'(tick_log.size()), 32'd1);
    check("abl_valid", 32'(n_valid), 32'd0);
    check("abl_req", 32'(sif.o_BUS_REQ), 32'd0);

    // Abort during bus wait of an END=0 word
    rom[8'h50] = 18'h00002;
    rom[8'h51] = 18'h08000;
    abort_phase = 2;
    done_delay = 3;
    run_instr(8'h50, "abort_bus");
    check("abb_ticks", 32'(tick_log.size()), 32'd1);
    check("abb_valid", 32'(n_valid), 32'd1);
    done_delay = 2;
    abort_phase = -1;

    // Address wrap sets the sticky error
    rom[8'hFF] = 18'h00001;
    rom[8'h00] = 18'h08000;
    run_instr(8'hFF, "wrap");
    check("wrap_ticks", 32'(tick_log.size()), 32'd2);
    if (tick_log.size() == 2) check("wrap_tick1", 32'(tick_log[1]), 32'h00);
    check("wrap_err", 32'(sif.o_SEQ_ERR), 32'd1);
    run_instr(8'h11, "wrap_hold");
    check("err_held", 32'(sif.o_SEQ_ERR), 32'd1);

    // Reset in the middle of a bus wait, with the clock enable low
    done_delay = 20;
    sif.i_DEC_ADDR = 8'h10;
    hold_dec = 1'b1;
    n = 0;
    do begin step(); n++; end while (!(!m_idle && m_phase == 2) && n < 50);
    check("rst_reach_bus", 32'(n < 50), 32'd1);
    step();
    rst_n = 1'b0;
    sif.i_CEN = 1'b0;
    cen_mode = 3;
    step();
    check("rst_ird",   32'(sif.o_IRD), 32'd1);
    check("rst_addr",  32'(sif.o_MCROM_ADDR), 32'hFF);
    check("rst_word",  32'(sif.o_MC_WORD), 32'd0);
    check("rst_tick",  32'(sif.o_MCROM_READ_TICK), 32'd0);
    check("rst_valid", 32'(sif.o_MC_VALID), 32'd0);
    check("rst_req",   32'(sif.o_BUS_REQ), 32'd0);
    check("rst_code",  32'(sif.o_BUS_CODE), 32'd0);
    check("rst_skip",  32'(sif.o_SKIP_PEND), 32'd0);
    check("rst_err",   32'(sif.o_SEQ_ERR), 32'd0);
    rst_n = 1'b1;
    cen_mode = 0;
    done_delay = 2;
    step();

    // Randomized phase against the model
    for (int i = 0; i < 256; i++) rom[i] = MC_W'($urandom);
    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rnd = 1'b0;
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
